// File: rtl/demux_1_8_deser_if.sv
// demux_1_8_deser_if: serial bit input and parallel frame output bundle
interface demux_1_8_deser_if #(parameter int N = 8);
    localparam int SEL_W = $clog2(N);
    logic din;
    logic din_valid;
    logic sync;
    logic [N-1:0] dout;
    logic dout_valid;
    logic [SEL_W-1:0] sel;
    logic frame_err;
    logic [7:0] frame_cnt;
    modport master (output din, din_valid, sync, input dout, dout_valid, sel, frame_err, frame_cnt);
    modport slave (input din, din_valid, sync, output dout, dout_valid, sel, frame_err, frame_cnt);
endinterface

// File: rtl/demux_1_8_deser.sv
// demux_1_8_deser: 1:N serial-to-parallel deserializer with frame strobe and resync detection
module demux_1_8_deser #(parameter int N = 8) (
    input logic clk,
    input logic rst,
    demux_1_8_deser_if.slave bus
);
    localparam int SEL_W = $clog2(N);
    logic [SEL_W-1:0] sel;
    logic [N-2:0] shadow;
    logic [N-1:0] dout;
    logic dout_valid;
    logic frame_err;
    logic [7:0] frame_cnt;
    logic last;
    assign last = sel == SEL_W'(N - 1);
    // the last lane bypasses the shadow so the frame is presented the cycle after its final bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel <= '0;
            shadow <= '0;
            dout <= '0;
            dout_valid <= 1'b0;
            frame_err <= 1'b0;
            frame_cnt <= '0;
        end else begin
            dout_valid <= 1'b0;
            frame_err <= 1'b0;
            if (bus.din_valid) begin
                if (bus.sync) begin
                    shadow[0] <= bus.din;
                    sel <= SEL_W'(1);
                    frame_err <= sel != '0;
                end else if (last) begin
                    dout <= {bus.din, shadow};
                    dout_valid <= 1'b1;
                    sel <= '0;
                    frame_cnt <= frame_cnt + 8'd1;
                end else begin
                    shadow[sel] <= bus.din;
                    sel <= sel + SEL_W'(1);
                end
            end
        end
    end
    assign bus.dout = dout;
    assign bus.dout_valid = dout_valid;
    assign bus.sel = sel;
    assign bus.frame_err = frame_err;
    assign bus.frame_cnt = frame_cnt;
endmodule

// File: tb/tb_demux_1_8_deser.sv
// tb_demux_1_8_deser: directed scoreboard bench for the 1:8 deserializer
module tb_demux_1_8_deser;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    int err_seen = 0;
    logic [7:0] exp_cnt = 8'd0;
    logic [15:0] q[$];
    demux_1_8_deser_if #(.N(8)) bus();
    demux_1_8_deser #(.N(8)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic step(input logic v, input logic s, input logic d);
        bus.din_valid = v;
        bus.sync = s;
        bus.din = d;
        @(posedge clk);
        #1;
    endtask
    task automatic send_frame(input logic [7:0] b, input bit s, input bit gap);
        exp_cnt++;
        q.push_back({b, exp_cnt});
        for (int k = 0; k < 8; k++) begin
            chk("sel_trace", 32'(bus.sel), k);
            step(1'b1, s && k == 0, b[k]);
            chk("valid_timing", 32'(bus.dout_valid), 32'(k == 7));
            if (gap && k < 7) step(1'b0, 1'($urandom), 1'($urandom));
        end
    endtask
    // scoreboard: every dout_valid pulse must match the oldest pushed frame
    always @(negedge clk) begin
        if (bus.frame_err === 1'b1) err_seen++;
        if (bus.dout_valid === 1'b1) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL sb_underflow observed dout=%0h expected no frame", bus.dout);
            end else begin
                logic [15:0] e;
                e = q.pop_front();
                chk("sb_dout", 32'(bus.dout), 32'(e[15:8]));
                chk("sb_cnt", 32'(bus.frame_cnt), 32'(e[7:0]));
            end
        end
    end
    initial begin
        bus.din = 1'b0;
        bus.din_valid = 1'b0;
        bus.sync = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout", 32'(bus.dout), 0);
        chk("rst_valid", 32'(bus.dout_valid), 0);
        chk("rst_sel", 32'(bus.sel), 0);
        chk("rst_err", 32'(bus.frame_err), 0);
        chk("rst_cnt", 32'(bus.frame_cnt), 0);
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        send_frame(8'h55, 1'b1, 1'b0);
        chk("basic_dout", 32'(bus.dout), 32'h55);
        chk("basic_cnt", 32'(bus.frame_cnt), 1);
        chk("basic_sel", 32'(bus.sel), 0);
        step(1'b0, 1'b1, 1'b1);
        chk("idle_valid", 32'(bus.dout_valid), 0);
        chk("idle_hold", 32'(bus.dout), 32'h55);
        chk("idle_sel", 32'(bus.sel), 0);
        for (int k = 0; k < 8; k++) begin
            logic [7:0] b;
            b = 8'd1 << k;
            send_frame(b, 1'b1, 1'b0);
            chk("walk_dout", 32'(bus.dout), 32'(b));
        end
        chk("walk_cnt", 32'(bus.frame_cnt), 9);
        send_frame(8'h55, 1'b1, 1'b1);
        chk("gap_dout", 32'(bus.dout), 32'h55);
        chk("gap_cnt", 32'(bus.frame_cnt), 10);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        chk("mid_sel", 32'(bus.sel), 3);
        chk("mid_no_err", 32'(bus.frame_err), 0);
        step(1'b1, 1'b1, 1'b1);
        chk("mid_err", 32'(bus.frame_err), 1);
        chk("mid_resync_sel", 32'(bus.sel), 1);
        chk("mid_dout_hold", 32'(bus.dout), 32'h55);
        chk("mid_cnt_hold", 32'(bus.frame_cnt), 10);
        chk("mid_valid", 32'(bus.dout_valid), 0);
        exp_cnt++;
        q.push_back({8'h01, exp_cnt});
        step(1'b1, 1'b0, 1'b0);
        chk("mid_err_clear", 32'(bus.frame_err), 0);
        repeat (5) step(1'b1, 1'b0, 1'b0);
        chk("mid_pre_valid", 32'(bus.dout_valid), 0);
        step(1'b1, 1'b0, 1'b0);
        chk("mid_valid_done", 32'(bus.dout_valid), 1);
        chk("mid_dout", 32'(bus.dout), 32'h01);
        chk("mid_cnt", 32'(bus.frame_cnt), 11);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("arst_dout", 32'(bus.dout), 0);
        chk("arst_valid", 32'(bus.dout_valid), 0);
        chk("arst_sel", 32'(bus.sel), 0);
        chk("arst_err", 32'(bus.frame_err), 0);
        chk("arst_cnt", 32'(bus.frame_cnt), 0);
        bus.din_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_cnt = 8'd0;
        for (int i = 0; i < 256; i++)
            send_frame(i[0] ? 8'h5A : 8'hA5, i % 3 == 1, 1'b0);
        chk("wrap_cnt", 32'(bus.frame_cnt), 0);
        chk("wrap_dout", 32'(bus.dout), 32'h5A);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("err_count", 32'(err_seen), 1);
        chk("sb_empty", 32'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/demux_1_8_deser.md
Name: demux_1_8_deser

Overview:
Serial-to-parallel 1:8 demultiplexer/deserializer. It is the receive end of an 8:1 mux driven by a 3-bit slot counter used as a serializer. One bit per valid cycle is steered into output lane S (S = slot counter, lane 0 first). After lane 7 is filled, all lanes are presented together with a one-cycle valid strobe. It sits after an 8:1 mux serializer link and restores D0..D7 in parallel.

Parameters:
N, 8, number of output lanes; must be a power of 2 and at least 2; SEL_W = $clog2(N) is a derived localparam.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
din  input  1  serial data bit.
din_valid  input  1  din is sampled this cycle when high.
sync  input  1  frame start; marks the current din as lane 0; qualified by din_valid.
dout  output  N  parallel frame; dout[k] is the bit received in slot k.
dout_valid  output  1  one-cycle pulse when dout updates.
sel  output  SEL_W  current slot counter S (the lane the next valid bit goes to).
frame_err  output  1  one-cycle pulse when sync arrives mid-frame.
frame_cnt  output  8  count of completed frames; wraps 255 -> 0.

Behaviour:
- Reset (async assert, sync release): sel=0, shadow=0, dout=0, dout_valid=0, frame_err=0, frame_cnt=0. A partial frame is discarded.
- State:
  - SEL_W-bit slot counter.
  - (N-1)-bit shadow register holding lanes 0..N-2.
  - Registered outputs.
- din_valid=0: no state change; dout_valid=0 and frame_err=0 next cycle; dout holds.
- din_valid=1, sync=0, sel<N-1: shadow[sel] <= din; sel <= sel+1.
- din_valid=1, sync=0, sel==N-1 (frame complete):
  - dout <= {din, shadow[N-2:0]}.
  - dout_valid <= 1 for exactly one cycle.
  - sel <= 0 (wrap).
  - frame_cnt <= frame_cnt+1 (mod 256).
- din_valid=1, sync=1:
  - Bit is lane 0: shadow[0] <= din; sel <= 1.
  - If sel != 0 at that edge, the partial frame is abandoned and frame_err pulses 1 cycle. dout, dout_valid and frame_cnt are not touched.
  - If sel==0, frame_err stays 0.
- sync with din_valid=0: ignored.
- Latency: dout/dout_valid are visible in the cycle after the edge that samples the N-th bit.
- Back-to-back frames with no idle cycles are supported; dout_valid may pulse every N cycles.
- dout holds its last frame until the next complete frame or reset.
- Shadow bits are not cleared between frames. They are always fully rewritten before use.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
1. Reset check: rst=1 mid-stream -> all outputs 0 immediately (asynchronous), sel=0. After release, the first valid bit goes to lane 0.
2. Basic frame: sync=1 on first bit, din_valid=1 for 8 cycles, bits 1,0,1,0,1,0,1,0 -> one cycle after the 8th bit, dout=8'h55, dout_valid=1 for one cycle, frame_cnt=1, sel=0.
3. Each select value: lane-walking frames with only bit k=1 for k=0..7 -> dout = 8'h01,02,04,...,80. This mirrors every S2S1S0 combination of the mux; sel traces 0..7 per frame.
4. Gapped valid: same 8'h55 pattern with din_valid=0 on alternate cycles -> identical dout=8'h55; dout_valid fires only after the 8th valid bit.
5. Mid-frame sync: 3 valid bits, then sync=1 with din=1, then 7 more bits 0 -> frame_err pulses once, dout=8'h01, frame_cnt +1 only.
6. Back-to-back and wrap: 256 continuous frames alternating 8'hA5/8'h5A -> dout_valid every 8th cycle with the correct data, and frame_cnt wraps to 0.
